// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the keypad calculator controller.
// Holds the key code constants, the controller state encoding, the default
// ALU latency and small helpers for classifying keys and shifting in digits.
package calc_pkg;

    // Number of cycles the ALU inputs are held before the result is sampled
    localparam int ALU_LAT_DEF = 2;

    // Key codes presented on key_code
    localparam logic [3:0] KEY_PLUS  = 4'd10;
    localparam logic [3:0] KEY_MINUS = 4'd11;
    localparam logic [3:0] KEY_EQ    = 4'd12;
    localparam logic [3:0] KEY_CLR   = 4'd13;

    // Maximum number of BCD digits per operand
    localparam logic [2:0] DIGITS_MAX = 3'd4;

    typedef enum logic [2:0] {
        ST_ENTRY_A = 3'd0,
        ST_ENTRY_B = 3'd1,
        ST_EXEC    = 3'd2,
        ST_SHOW    = 3'd3,
        ST_ERROR   = 3'd4
    } calc_state_e;

    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

    function automatic logic is_op(input logic [3:0] code);
        return (code == KEY_PLUS) || (code == KEY_MINUS);
    endfunction

    // Shift a 4-digit BCD value left by one digit, appending d
    function automatic logic [15:0] shift_in(input logic [15:0] x, input logic [3:0] d);
        return {x[11:0], d};
    endfunction

endpackage

// File: rtl/bcd_ovf_chk.sv
// bcd_ovf_chk: combinational decimal carry out of digit 3 for a + b.
// Ports:
//   a, b  : 4-digit BCD operands
//   carry : 1 when the decimal sum does not fit in 4 digits
module bcd_ovf_chk (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        carry
);

    logic [4:0] dsum_s;
    logic       c_s;

    // Ripple a decimal carry through the four digits
    always_comb begin
        dsum_s = 5'd0;
        c_s    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dsum_s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'd0, c_s};
            if (dsum_s > 5'd9) begin
                c_s = 1'b1;
            end else begin
                c_s = 1'b0;
            end
        end
        carry = c_s;
    end

endmodule

// File: rtl/calc_ctrl.sv
// calc_ctrl: keypad-driven controller for a 4-digit BCD add/subtract ALU.
// Collects operand A and B digits from keypad strobes, drives the ALU with
// stable operands for ALU_LAT cycles, captures the result and shows it.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   key_valid, key_code  : one-cycle keypad strobe and code
//   alu_a, alu_b, alu_op : operands and op (1 = add) to the ALU
//   alu_res, alu_ovf,
//   alu_sign             : ALU magnitude result and flags
//   disp, disp_neg       : display value and minus sign
//   err, busy, res_valid : error state, EXEC in progress, result strobe
module calc_ctrl
    import calc_pkg::*;
#(
    parameter int ALU_LAT = ALU_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic        alu_op,
    input  logic [15:0] alu_res,
    input  logic        alu_ovf,
    input  logic        alu_sign,
    output logic [15:0] disp,
    output logic        disp_neg,
    output logic        err,
    output logic        busy,
    output logic        res_valid
);

    calc_state_e state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [2:0]  a_cnt_q, a_cnt_d;
    logic [2:0]  b_cnt_q, b_cnt_d;
    logic        op_q, op_d;
    logic [15:0] res_q, res_d;
    logic        sign_q, sign_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] disp_q, disp_d;
    logic        disp_neg_q, disp_neg_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic        res_valid_q, res_valid_d;
    logic        carry_s;
    logic        ovf_s;

    bcd_ovf_chk u_ovf_chk (
        .a     (a_q),
        .b     (b_q),
        .carry (carry_s)
    );

    // Local decimal carry only matters for addition
    assign ovf_s = alu_ovf | (op_q & carry_s);

    // Next-state, operand and output computation
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        a_cnt_d     = a_cnt_q;
        b_cnt_d     = b_cnt_q;
        op_d        = op_q;
        res_d       = res_q;
        sign_d      = sign_q;
        cnt_d       = cnt_q;
        res_valid_d = 1'b0;

        // Clear works everywhere except EXEC, where keys are dropped
        if (key_valid && (key_code == KEY_CLR) && (state_q != ST_EXEC)) begin
            a_d     = 16'd0;
            b_d     = 16'd0;
            a_cnt_d = 3'd0;
            b_cnt_d = 3'd0;
            res_d   = 16'd0;
            sign_d  = 1'b0;
            cnt_d   = 8'd0;
            state_d = ST_ENTRY_A;
        end else begin
            case (state_q)
                ST_ENTRY_A: begin
                    if (key_valid && is_digit(key_code)) begin
                        if (a_cnt_q < DIGITS_MAX) begin
                            a_d     = shift_in(a_q, key_code);
                            a_cnt_d = a_cnt_q + 3'd1;
                        end else begin
                            a_d = a_q;
                        end
                    end else if (key_valid && is_op(key_code)) begin
                        op_d    = (key_code == KEY_PLUS);
                        b_d     = 16'd0;
                        b_cnt_d = 3'd0;
                        state_d = ST_ENTRY_B;
                    end else begin
                        state_d = ST_ENTRY_A;
                    end
                end
                ST_ENTRY_B: begin
                    if (key_valid && is_digit(key_code)) begin
                        if (b_cnt_q < DIGITS_MAX) begin
                            b_d     = shift_in(b_q, key_code);
                            b_cnt_d = b_cnt_q + 3'd1;
                        end else begin
                            b_d = b_q;
                        end
                    end else if (key_valid && is_op(key_code)) begin
                        // Operator can only be changed before B has digits
                        if (b_cnt_q == 3'd0) begin
                            op_d = (key_code == KEY_PLUS);
                        end else begin
                            op_d = op_q;
                        end
                    end else if (key_valid && (key_code == KEY_EQ)) begin
                        cnt_d   = 8'd0;
                        state_d = ST_EXEC;
                    end else begin
                        state_d = ST_ENTRY_B;
                    end
                end
                ST_EXEC: begin
                    // Operands held for cnt 0..ALU_LAT-1, sample on cnt == ALU_LAT
                    if (cnt_q == 8'(ALU_LAT)) begin
                        res_d       = alu_res;
                        sign_d      = alu_sign;
                        res_valid_d = 1'b1;
                        cnt_d       = 8'd0;
                        state_d     = ovf_s ? ST_ERROR : ST_SHOW;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_SHOW: begin
                    if (key_valid && is_digit(key_code)) begin
                        a_d     = {12'd0, key_code};
                        a_cnt_d = 3'd1;
                        state_d = ST_ENTRY_A;
                    end else if (key_valid && is_op(key_code)) begin
                        // A negative result cannot be chained as a magnitude
                        if (!sign_q) begin
                            a_d     = res_q;
                            a_cnt_d = DIGITS_MAX;
                            op_d    = (key_code == KEY_PLUS);
                            b_d     = 16'd0;
                            b_cnt_d = 3'd0;
                            state_d = ST_ENTRY_B;
                        end else begin
                            state_d = ST_SHOW;
                        end
                    end else begin
                        state_d = ST_SHOW;
                    end
                end
                ST_ERROR: begin
                    state_d = ST_ERROR;
                end
                default: begin
                    state_d = ST_ERROR;
                end
            endcase
        end

        // Outputs are registered, so derive them from the next state
        case (state_d)
            ST_ENTRY_A:        disp_d = a_d;
            ST_ENTRY_B, ST_EXEC: disp_d = b_d;
            ST_SHOW:           disp_d = res_d;
            ST_ERROR:          disp_d = 16'd0;
            default:           disp_d = 16'd0;
        endcase
        disp_neg_d = (state_d == ST_SHOW) && sign_d;
        err_d      = (state_d == ST_ERROR);
        busy_d     = (state_d == ST_EXEC);
    end

    // State, operand and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ENTRY_A;
            a_q         <= 16'd0;
            b_q         <= 16'd0;
            a_cnt_q     <= 3'd0;
            b_cnt_q     <= 3'd0;
            op_q        <= 1'b1;
            res_q       <= 16'd0;
            sign_q      <= 1'b0;
            cnt_q       <= 8'd0;
            disp_q      <= 16'd0;
            disp_neg_q  <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            a_cnt_q     <= a_cnt_d;
            b_cnt_q     <= b_cnt_d;
            op_q        <= op_d;
            res_q       <= res_d;
            sign_q      <= sign_d;
            cnt_q       <= cnt_d;
            disp_q      <= disp_d;
            disp_neg_q  <= disp_neg_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_op    = op_q;
    assign disp      = disp_q;
    assign disp_neg  = disp_neg_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign res_valid = res_valid_q;

endmodule

// File: tb/tb_calc_ctrl.sv
// tb_calc_ctrl: directed self-checking bench for calc_ctrl.
// The ALU is modelled by driving alu_res/alu_sign/alu_ovf with the
// hand-computed answer for each vector before equals is pressed.
module tb_calc_ctrl;

    localparam int LAT = 2;

    logic        clk;
    logic        rst_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_op;
    logic [15:0] alu_res;
    logic        alu_ovf;
    logic        alu_sign;
    logic [15:0] disp;
    logic        disp_neg;
    logic        err;
    logic        busy;
    logic        res_valid;

    int n_checks;
    int n_errors;

    calc_ctrl #(.ALU_LAT(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_code  (key_code),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_res   (alu_res),
        .alu_ovf   (alu_ovf),
        .alu_sign  (alu_sign),
        .disp      (disp),
        .disp_neg  (disp_neg),
        .err       (err),
        .busy      (busy),
        .res_valid (res_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One-cycle key strobe; returns on the falling edge after it was taken
    task automatic press(input logic [3:0] k);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'd0;
    endtask

    // Called right after '=' was taken; checks result latency, pulse width
    // and that operands stay stable while the ALU works
    task automatic wait_res(input logic [15:0] ea, input logic [15:0] eb, input logic eop);
        int seen;
        seen = 0;
        check("busy_exec", {15'd0, busy}, 16'd1);
        for (int k = 1; k <= LAT + 6; k++) begin
            @(negedge clk);
            if (seen == 0 && res_valid) begin
                seen = k;
                break;
            end
            check("hold_a", alu_a, ea);
            check("hold_b", alu_b, eb);
            check("hold_op", {15'd0, alu_op}, {15'd0, eop});
        end
        check("rv_latency", 16'(seen), 16'(LAT + 1));
        @(negedge clk);
        check("rv_pulse", {15'd0, res_valid}, 16'd0);
        check("busy_done", {15'd0, busy}, 16'd0);
    endtask

    initial begin
        int rv_cnt;
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'd0;
        alu_res   = 16'd0;
        alu_ovf   = 1'b0;
        alu_sign  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_disp", disp, 16'h0000);
        check("rst_op", {15'd0, alu_op}, 16'd1);
        check("rst_a", alu_a, 16'h0000);
        check("rst_flags", {11'd0, err, busy, res_valid, disp_neg, 1'b0}, 16'd0);
        rst_n = 1'b1;

        // 10 + 15 = 25
        press(4'd1); press(4'd0);
        check("t1_dispA", disp, 16'h0010);
        press(4'd10);
        check("t1_dispB0", disp, 16'h0000);
        press(4'd1); press(4'd5);
        check("t1_a", alu_a, 16'h0010);
        check("t1_b", alu_b, 16'h0015);
        check("t1_op", {15'd0, alu_op}, 16'd1);
        alu_res = 16'h0025; alu_sign = 1'b0; alu_ovf = 1'b0;
        press(4'd12);
        wait_res(16'h0010, 16'h0015, 1'b1);
        check("t1_disp", disp, 16'h0025);
        check("t1_neg", {15'd0, disp_neg}, 16'd0);
        press(4'd13);

        // 9876 + 0200 overflows through the local decimal carry
        press(4'd9); press(4'd8); press(4'd7); press(4'd6);
        press(4'd10);
        press(4'd2); press(4'd0); press(4'd0);
        alu_res = 16'h0076; alu_sign = 1'b0; alu_ovf = 1'b0;
        press(4'd12);
        wait_res(16'h9876, 16'h0200, 1'b1);
        check("t2_err", {15'd0, err}, 16'd1);
        check("t2_disp", disp, 16'h0000);
        press(4'd5);
        check("t2_key_ign", disp, 16'h0000);
        check("t2_err_hold", {15'd0, err}, 16'd1);
        press(4'd13);
        check("t2_clr_err", {15'd0, err}, 16'd0);
        press(4'd3);
        check("t2_entryA", disp, 16'h0003);
        press(4'd13);

        // 3 - 8 = -5, negative result cannot be chained
        press(4'd3); press(4'd11); press(4'd8);
        check("t3_op", {15'd0, alu_op}, 16'd0);
        alu_res = 16'h0005; alu_sign = 1'b1; alu_ovf = 1'b0;
        press(4'd12);
        wait_res(16'h0003, 16'h0008, 1'b0);
        check("t3_disp", disp, 16'h0005);
        check("t3_neg", {15'd0, disp_neg}, 16'd1);
        press(4'd10);
        check("t3_plus_ign", disp, 16'h0005);
        check("t3_plus_neg", {15'd0, disp_neg}, 16'd1);
        press(4'd4);
        check("t3_new_a", disp, 16'h0004);
        check("t3_new_neg", {15'd0, disp_neg}, 16'd0);
        press(4'd13);

        // Fifth digit, reserved codes and equals in ENTRY_A are ignored
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
        check("t4_5th", disp, 16'h1234);
        press(4'd14);
        check("t4_k14", disp, 16'h1234);
        press(4'd15);
        check("t4_k15", disp, 16'h1234);
        press(4'd12);
        check("t4_eq_busy", {15'd0, busy}, 16'd0);
        check("t4_eq_disp", disp, 16'h1234);
        press(4'd13);

        // Operator replaced before B digits; model ALU returns 0 here
        press(4'd1); press(4'd10); press(4'd11);
        check("t5_op_repl", {15'd0, alu_op}, 16'd0);
        press(4'd2);
        alu_res = 16'h0000; alu_sign = 1'b0; alu_ovf = 1'b0;
        press(4'd12);
        wait_res(16'h0001, 16'h0002, 1'b0);
        check("t5_disp0", disp, 16'h0000);
        press(4'd10);
        check("t5_chain_a", alu_a, 16'h0000);
        press(4'd3);
        press(4'd11);
        check("t5_op_keep", {15'd0, alu_op}, 16'd1);
        check("t5_b", alu_b, 16'h0003);
        alu_res = 16'h0003;
        press(4'd12);
        wait_res(16'h0000, 16'h0003, 1'b1);
        check("t5_disp3", disp, 16'h0003);
        press(4'd13);

        // Reset in the middle of EXEC aborts the operation
        press(4'd5); press(4'd10); press(4'd5);
        alu_res = 16'h0010; alu_sign = 1'b0; alu_ovf = 1'b0;
        press(4'd12);
        check("t6_busy", {15'd0, busy}, 16'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_a", alu_a, 16'h0000);
        check("t6_rst_b", alu_b, 16'h0000);
        check("t6_rst_op", {15'd0, alu_op}, 16'd1);
        check("t6_rst_disp", disp, 16'h0000);
        check("t6_rst_flags", {12'd0, err, busy, res_valid, disp_neg}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rv_cnt = 0;
        for (int k = 0; k < LAT + 4; k++) begin
            @(negedge clk);
            if (res_valid) rv_cnt++;
        end
        check("t6_no_rv", 16'(rv_cnt), 16'd0);
        press(4'd7);
        check("t6_entryA", disp, 16'h0007);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Guard against a hung run
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
